// File: rtl/axi_bus_mux.sv
// Routes AXI4 channels of M1/M2 to slave S, with the owner held per path until the write response or RLAST completes.
// Zero-cycle combinational forwarding; READY/VALID pass straight through to the owner, and the non-owner sees only zeros.
module axi_bus_mux #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                aclk,
   input  logic                rst_n,
   input  logic                m1_grant_w,
   input  logic                m2_grant_w,
   input  logic                m1_grant_r,
   input  logic                m2_grant_r,
   input  logic [ADDR_W-1:0]   M1_AWADDR,
   input  logic                M1_AWVALID,
   output logic                M1_AWREADY,
   input  logic [DATA_W-1:0]   M1_WDATA,
   input  logic [DATA_W/8-1:0] M1_WSTRB,
   input  logic                M1_WLAST,
   input  logic                M1_WVALID,
   output logic                M1_WREADY,
   output logic [1:0]          M1_BRESP,
   output logic                M1_BVALID,
   input  logic                M1_BREADY,
   input  logic [ADDR_W-1:0]   M1_ARADDR,
   input  logic                M1_ARVALID,
   output logic                M1_ARREADY,
   output logic [DATA_W-1:0]   M1_RDATA,
   output logic [1:0]          M1_RRESP,
   output logic                M1_RLAST,
   output logic                M1_RVALID,
   input  logic                M1_RREADY,
   input  logic [ADDR_W-1:0]   M2_AWADDR,
   input  logic                M2_AWVALID,
   output logic                M2_AWREADY,
   input  logic [DATA_W-1:0]   M2_WDATA,
   input  logic [DATA_W/8-1:0] M2_WSTRB,
   input  logic                M2_WLAST,
   input  logic                M2_WVALID,
   output logic                M2_WREADY,
   output logic [1:0]          M2_BRESP,
   output logic                M2_BVALID,
   input  logic                M2_BREADY,
   input  logic [ADDR_W-1:0]   M2_ARADDR,
   input  logic                M2_ARVALID,
   output logic                M2_ARREADY,
   output logic [DATA_W-1:0]   M2_RDATA,
   output logic [1:0]          M2_RRESP,
   output logic                M2_RLAST,
   output logic                M2_RVALID,
   input  logic                M2_RREADY,
   output logic [ADDR_W-1:0]   S_AWADDR,
   output logic                S_AWVALID,
   input  logic                S_AWREADY,
   output logic [DATA_W-1:0]   S_WDATA,
   output logic [DATA_W/8-1:0] S_WSTRB,
   output logic                S_WLAST,
   output logic                S_WVALID,
   input  logic                S_WREADY,
   input  logic [1:0]          S_BRESP,
   input  logic                S_BVALID,
   output logic                S_BREADY,
   output logic [ADDR_W-1:0]   S_ARADDR,
   output logic                S_ARVALID,
   input  logic                S_ARREADY,
   input  logic [DATA_W-1:0]   S_RDATA,
   input  logic [1:0]          S_RRESP,
   input  logic                S_RLAST,
   input  logic                S_RVALID,
   output logic                S_RREADY
);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_e;
   typedef enum logic       {OWN_M1, OWN_M2}         owner_e;

   w_state_e   w_state_q, w_state_d;
   r_state_e   r_state_q, r_state_d;
   owner_e     w_owner_q, w_owner_d, r_owner_q, r_owner_d;
   logic [7:0] w_beats_q, w_beats_d, r_beats_q, r_beats_d;
   logic       r_hs;

   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         w_owner_q <= OWN_M1;
         r_owner_q <= OWN_M1;
         w_beats_q <= '0;
         r_beats_q <= '0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         w_owner_q <= w_owner_d;
         r_owner_q <= r_owner_d;
         w_beats_q <= w_beats_d;
         r_beats_q <= r_beats_d;
      end
   end

   // Routing is gated by rst_n so every handshake output drops the moment reset asserts.
   always_comb begin
      w_state_d  = w_state_q;
      w_owner_d  = w_owner_q;
      w_beats_d  = w_beats_q;
      S_AWADDR   = '0;
      S_AWVALID  = 1'b0;
      S_WDATA    = '0;
      S_WSTRB    = '0;
      S_WLAST    = 1'b0;
      S_WVALID   = 1'b0;
      S_BREADY   = 1'b0;
      M1_AWREADY = 1'b0;
      M2_AWREADY = 1'b0;
      M1_WREADY  = 1'b0;
      M2_WREADY  = 1'b0;
      M1_BVALID  = 1'b0;
      M2_BVALID  = 1'b0;
      M1_BRESP   = '0;
      M2_BRESP   = '0;
      if (rst_n) begin
         unique case (w_state_q)
            W_IDLE: begin
               if (m1_grant_w) begin
                  S_AWADDR   = M1_AWADDR;
                  S_AWVALID  = M1_AWVALID;
                  M1_AWREADY = S_AWREADY;
                  if (M1_AWVALID && S_AWREADY) begin
                     w_owner_d = OWN_M1;
                     w_state_d = W_DATA;
                     w_beats_d = '0;
                  end
               end else if (m2_grant_w) begin
                  S_AWADDR   = M2_AWADDR;
                  S_AWVALID  = M2_AWVALID;
                  M2_AWREADY = S_AWREADY;
                  if (M2_AWVALID && S_AWREADY) begin
                     w_owner_d = OWN_M2;
                     w_state_d = W_DATA;
                     w_beats_d = '0;
                  end
               end
            end
            W_DATA: begin
               if (w_owner_q == OWN_M1) begin
                  S_WDATA   = M1_WDATA;
                  S_WSTRB   = M1_WSTRB;
                  S_WLAST   = M1_WLAST;
                  S_WVALID  = M1_WVALID;
                  M1_WREADY = S_WREADY;
               end else begin
                  S_WDATA   = M2_WDATA;
                  S_WSTRB   = M2_WSTRB;
                  S_WLAST   = M2_WLAST;
                  S_WVALID  = M2_WVALID;
                  M2_WREADY = S_WREADY;
               end
               if (S_WVALID && S_WREADY) begin
                  w_beats_d = w_beats_q + 8'd1;
                  if (S_WLAST) w_state_d = W_RESP;
               end
            end
            W_RESP: begin
               if (w_owner_q == OWN_M1) begin
                  M1_BVALID = S_BVALID;
                  M1_BRESP  = S_BRESP;
                  S_BREADY  = M1_BREADY;
               end else begin
                  M2_BVALID = S_BVALID;
                  M2_BRESP  = S_BRESP;
                  S_BREADY  = M2_BREADY;
               end
               if (S_BVALID && S_BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
         endcase
      end
   end

   assign r_hs = S_RVALID && ((r_owner_q == OWN_M1) ? M1_RREADY : M2_RREADY);

   always_comb begin
      r_state_d  = r_state_q;
      r_owner_d  = r_owner_q;
      r_beats_d  = r_beats_q;
      S_ARADDR   = '0;
      S_ARVALID  = 1'b0;
      S_RREADY   = 1'b0;
      M1_ARREADY = 1'b0;
      M2_ARREADY = 1'b0;
      M1_RDATA   = '0;
      M1_RRESP   = '0;
      M1_RLAST   = 1'b0;
      M1_RVALID  = 1'b0;
      M2_RDATA   = '0;
      M2_RRESP   = '0;
      M2_RLAST   = 1'b0;
      M2_RVALID  = 1'b0;
      if (rst_n) begin
         unique case (r_state_q)
            R_IDLE: begin
               if (m1_grant_r) begin
                  S_ARADDR   = M1_ARADDR;
                  S_ARVALID  = M1_ARVALID;
                  M1_ARREADY = S_ARREADY;
                  if (M1_ARVALID && S_ARREADY) begin
                     r_owner_d = OWN_M1;
                     r_state_d = R_DATA;
                     r_beats_d = '0;
                  end
               end else if (m2_grant_r) begin
                  S_ARADDR   = M2_ARADDR;
                  S_ARVALID  = M2_ARVALID;
                  M2_ARREADY = S_ARREADY;
                  if (M2_ARVALID && S_ARREADY) begin
                     r_owner_d = OWN_M2;
                     r_state_d = R_DATA;
                     r_beats_d = '0;
                  end
               end
            end
            R_DATA: begin
               if (r_owner_q == OWN_M1) begin
                  M1_RDATA  = S_RDATA;
                  M1_RRESP  = S_RRESP;
                  M1_RLAST  = S_RLAST;
                  M1_RVALID = S_RVALID;
                  S_RREADY  = M1_RREADY;
               end else begin
                  M2_RDATA  = S_RDATA;
                  M2_RRESP  = S_RRESP;
                  M2_RLAST  = S_RLAST;
                  M2_RVALID = S_RVALID;
                  S_RREADY  = M2_RREADY;
               end
               if (r_hs) begin
                  r_beats_d = r_beats_q + 8'd1;
                  if (S_RLAST) r_state_d = R_IDLE;
               end
            end
            default: r_state_d = R_IDLE;
         endcase
      end
   end

   // Beats may only be counted while a data phase is active or being entered.
   always_ff @(posedge aclk) begin
      if (rst_n && w_state_q != W_DATA && w_state_d != W_DATA)
         assert (w_beats_d == w_beats_q);
      if (rst_n && r_state_q != R_DATA && r_state_d != R_DATA)
         assert (r_beats_d == r_beats_q);
   end

endmodule

// File: tb/tb_axi_bus_mux.sv
// Scoreboard bench for axi_bus_mux: W and R beats are queued when driven and checked where they emerge.
module tb_axi_bus_mux;
   logic        aclk = 1'b0;
   logic        rst_n = 1'b1;
   logic        m1_grant_w, m2_grant_w, m1_grant_r, m2_grant_r;
   logic [31:0] M1_AWADDR, M2_AWADDR, M1_ARADDR, M2_ARADDR, S_AWADDR, S_ARADDR;
   logic        M1_AWVALID, M2_AWVALID, M1_AWREADY, M2_AWREADY, S_AWVALID, S_AWREADY;
   logic [31:0] M1_WDATA, M2_WDATA, S_WDATA;
   logic [3:0]  M1_WSTRB, M2_WSTRB, S_WSTRB;
   logic        M1_WLAST, M2_WLAST, S_WLAST, M1_WVALID, M2_WVALID, S_WVALID;
   logic        M1_WREADY, M2_WREADY, S_WREADY;
   logic [1:0]  M1_BRESP, M2_BRESP, S_BRESP;
   logic        M1_BVALID, M2_BVALID, S_BVALID, M1_BREADY, M2_BREADY, S_BREADY;
   logic        M1_ARVALID, M2_ARVALID, S_ARVALID, M1_ARREADY, M2_ARREADY, S_ARREADY;
   logic [31:0] M1_RDATA, M2_RDATA, S_RDATA;
   logic [1:0]  M1_RRESP, M2_RRESP, S_RRESP;
   logic        M1_RLAST, M2_RLAST, S_RLAST, M1_RVALID, M2_RVALID, S_RVALID;
   logic        M1_RREADY, M2_RREADY, S_RREADY;

   int          checks = 0;
   int          failures = 0;
   logic [32:0] wq[$];
   logic [32:0] rq[$];

   logic [4:0]  m1_w, m2_w;
   logic [36:0] m1_r, m2_r;
   logic [17:0] all_vr;
   assign m1_w = {M1_AWREADY, M1_WREADY, M1_BVALID, M1_BRESP};
   assign m2_w = {M2_AWREADY, M2_WREADY, M2_BVALID, M2_BRESP};
   assign m1_r = {M1_ARREADY, M1_RVALID, M1_RLAST, M1_RRESP, M1_RDATA};
   assign m2_r = {M2_ARREADY, M2_RVALID, M2_RLAST, M2_RRESP, M2_RDATA};
   assign all_vr = {M1_AWREADY, M1_WREADY, M1_BVALID, M1_ARREADY, M1_RVALID, M1_RLAST,
                    M2_AWREADY, M2_WREADY, M2_BVALID, M2_ARREADY, M2_RVALID, M2_RLAST,
                    S_AWVALID, S_WVALID, S_WLAST, S_BREADY, S_ARVALID, S_RREADY};

   always #5 aclk = ~aclk;

   axi_bus_mux #(.ADDR_W(32), .DATA_W(32)) dut (
      .aclk(aclk), .rst_n(rst_n),
      .m1_grant_w(m1_grant_w), .m2_grant_w(m2_grant_w),
      .m1_grant_r(m1_grant_r), .m2_grant_r(m2_grant_r),
      .M1_AWADDR(M1_AWADDR), .M1_AWVALID(M1_AWVALID), .M1_AWREADY(M1_AWREADY),
      .M1_WDATA(M1_WDATA), .M1_WSTRB(M1_WSTRB), .M1_WLAST(M1_WLAST),
      .M1_WVALID(M1_WVALID), .M1_WREADY(M1_WREADY),
      .M1_BRESP(M1_BRESP), .M1_BVALID(M1_BVALID), .M1_BREADY(M1_BREADY),
      .M1_ARADDR(M1_ARADDR), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
      .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP), .M1_RLAST(M1_RLAST),
      .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
      .M2_AWADDR(M2_AWADDR), .M2_AWVALID(M2_AWVALID), .M2_AWREADY(M2_AWREADY),
      .M2_WDATA(M2_WDATA), .M2_WSTRB(M2_WSTRB), .M2_WLAST(M2_WLAST),
      .M2_WVALID(M2_WVALID), .M2_WREADY(M2_WREADY),
      .M2_BRESP(M2_BRESP), .M2_BVALID(M2_BVALID), .M2_BREADY(M2_BREADY),
      .M2_ARADDR(M2_ARADDR), .M2_ARVALID(M2_ARVALID), .M2_ARREADY(M2_ARREADY),
      .M2_RDATA(M2_RDATA), .M2_RRESP(M2_RRESP), .M2_RLAST(M2_RLAST),
      .M2_RVALID(M2_RVALID), .M2_RREADY(M2_RREADY),
      .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
      .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
      .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
      .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
      .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
      .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
      .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
   );

   function automatic logic [4:0] w_of(input int m);
      return (m == 1) ? m1_w : m2_w;
   endfunction

   function automatic logic [36:0] r_of(input int m);
      return (m == 1) ? m1_r : m2_r;
   endfunction

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic clear_inputs();
      {m1_grant_w, m2_grant_w, m1_grant_r, m2_grant_r} = '0;
      {M1_AWADDR, M1_AWVALID, M1_WDATA, M1_WSTRB, M1_WLAST, M1_WVALID, M1_BREADY} = '0;
      {M1_ARADDR, M1_ARVALID, M1_RREADY} = '0;
      {M2_AWADDR, M2_AWVALID, M2_WDATA, M2_WSTRB, M2_WLAST, M2_WVALID, M2_BREADY} = '0;
      {M2_ARADDR, M2_ARVALID, M2_RREADY} = '0;
      {S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY} = '0;
      {S_RDATA, S_RRESP, S_RLAST, S_RVALID} = '0;
   endtask

   task automatic aw_phase(input int m, input logic [31:0] addr);
      if (m == 1) begin M1_AWADDR = addr; M1_AWVALID = 1'b1; end
      else        begin M2_AWADDR = addr; M2_AWVALID = 1'b1; end
      S_AWREADY = 1'b1;
      @(negedge aclk);
      checks++;
      if ({S_AWVALID, S_AWADDR} !== {1'b1, addr}) begin
         failures++;
         $display("FAIL aw_fwd m%0d got %b/%h want 1/%h", m, S_AWVALID, S_AWADDR, addr);
      end
      checks++;
      if (w_of(m)[4] !== 1'b1) begin
         failures++;
         $display("FAIL aw_rdy m%0d got %b want 1", m, w_of(m)[4]);
      end
      checks++;
      if (w_of(3 - m) !== '0) begin
         failures++;
         $display("FAIL aw_iso m%0d got %b want 0", 3 - m, w_of(3 - m));
      end
      tick();
      M1_AWVALID = 1'b0;
      M2_AWVALID = 1'b0;
      S_AWREADY  = 1'b0;
   endtask

   task automatic w_burst(input int m, input int n, input logic [31:0] base, input bit ends);
      logic [32:0] exp;
      for (int i = 0; i < n; i++) begin
         logic        l;
         logic [31:0] d;
         l = ends && (i == n - 1);
         d = base + 32'(i);
         if (m == 1) begin M1_WDATA = d; M1_WSTRB = 4'hF; M1_WLAST = l; M1_WVALID = 1'b1; end
         else        begin M2_WDATA = d; M2_WSTRB = 4'hF; M2_WLAST = l; M2_WVALID = 1'b1; end
         S_WREADY = 1'b1;
         wq.push_back({l, d});
         @(negedge aclk);
         checks++;
         if (S_WVALID !== 1'b1) begin
            failures++;
            $display("FAIL w_fwd m%0d beat %0d S_WVALID got %b want 1", m, i, S_WVALID);
         end else begin
            exp = wq.pop_front();
            checks++;
            if ({S_WLAST, S_WDATA} !== exp) begin
               failures++;
               $display("FAIL w_data m%0d beat %0d got %h want %h", m, i, {S_WLAST, S_WDATA}, exp);
            end
         end
         checks++;
         if (w_of(m)[3] !== 1'b1) begin
            failures++;
            $display("FAIL w_rdy m%0d beat %0d got %b want 1", m, i, w_of(m)[3]);
         end
         checks++;
         if ({w_of(m)[2], S_BREADY} !== 2'b00) begin
            failures++;
            $display("FAIL b_block m%0d got %b%b want 00", m, w_of(m)[2], S_BREADY);
         end
         checks++;
         if (w_of(3 - m) !== '0) begin
            failures++;
            $display("FAIL w_iso m%0d got %b want 0", 3 - m, w_of(3 - m));
         end
         tick();
      end
      {M1_WVALID, M1_WLAST, M2_WVALID, M2_WLAST, S_WREADY} = '0;
   endtask

   task automatic b_phase(input int m, input logic [1:0] resp);
      S_BVALID = 1'b1;
      S_BRESP  = resp;
      if (m == 1) M1_BREADY = 1'b1; else M2_BREADY = 1'b1;
      @(negedge aclk);
      checks++;
      if (w_of(m)[2:0] !== {1'b1, resp}) begin
         failures++;
         $display("FAIL b_fwd m%0d got %b want %b", m, w_of(m)[2:0], {1'b1, resp});
      end
      checks++;
      if (S_BREADY !== 1'b1) begin
         failures++;
         $display("FAIL b_rdy m%0d got %b want 1", m, S_BREADY);
      end
      checks++;
      if (w_of(3 - m) !== '0) begin
         failures++;
         $display("FAIL b_iso m%0d got %b want 0", 3 - m, w_of(3 - m));
      end
      tick();
      {S_BVALID, S_BRESP, M1_BREADY, M2_BREADY} = '0;
   endtask

   task automatic ar_phase(input int m, input logic [31:0] addr);
      if (m == 1) begin M1_ARADDR = addr; M1_ARVALID = 1'b1; end
      else        begin M2_ARADDR = addr; M2_ARVALID = 1'b1; end
      S_ARREADY = 1'b1;
      @(negedge aclk);
      checks++;
      if ({S_ARVALID, S_ARADDR} !== {1'b1, addr}) begin
         failures++;
         $display("FAIL ar_fwd m%0d got %b/%h want 1/%h", m, S_ARVALID, S_ARADDR, addr);
      end
      checks++;
      if (r_of(m)[36] !== 1'b1) begin
         failures++;
         $display("FAIL ar_rdy m%0d got %b want 1", m, r_of(m)[36]);
      end
      checks++;
      if (r_of(3 - m) !== '0) begin
         failures++;
         $display("FAIL ar_iso m%0d got %h want 0", 3 - m, r_of(3 - m));
      end
      tick();
      if (m == 1) M1_ARVALID = 1'b0; else M2_ARVALID = 1'b0;
      S_ARREADY = 1'b0;
   endtask

   task automatic r_burst(input int m, input int n, input logic [31:0] base, input bit toggle);
      int          got = 0;
      int          cyc = 0;
      bit          pending = 0;
      logic        rr;
      logic [32:0] exp;
      while (got < n && cyc < n * 4 + 8) begin
         if (!pending) begin
            S_RDATA  = base + 32'(got);
            S_RLAST  = (got == n - 1);
            S_RRESP  = 2'b00;
            S_RVALID = 1'b1;
            rq.push_back({S_RLAST, S_RDATA});
            pending = 1;
         end
         rr = toggle ? logic'(cyc % 2) : 1'b1;
         if (m == 1) M1_RREADY = rr; else M2_RREADY = rr;
         @(negedge aclk);
         checks++;
         if (S_RREADY !== rr) begin
            failures++;
            $display("FAIL r_rdy_route m%0d got %b want %b", m, S_RREADY, rr);
         end
         checks++;
         if (r_of(m)[35] !== 1'b1) begin
            failures++;
            $display("FAIL r_vld m%0d got %b want 1", m, r_of(m)[35]);
         end else if (rr) begin
            exp = rq.pop_front();
            checks++;
            if ({r_of(m)[34], r_of(m)[31:0]} !== exp) begin
               failures++;
               $display("FAIL r_data m%0d beat %0d got %h want %h", m, got,
                        {r_of(m)[34], r_of(m)[31:0]}, exp);
            end
            got++;
            pending = 0;
         end
         checks++;
         if (r_of(3 - m) !== '0) begin
            failures++;
            $display("FAIL r_iso m%0d got %h want 0", 3 - m, r_of(3 - m));
         end
         tick();
         cyc++;
      end
      checks++;
      if (got != n) begin
         failures++;
         $display("FAIL r_timeout m%0d beats got %0d want %0d", m, got, n);
      end
      {S_RVALID, S_RLAST, S_RDATA, M1_RREADY, M2_RREADY} = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      {m1_grant_w, m2_grant_w, m1_grant_r, m2_grant_r} = 4'hF;
      {M1_AWVALID, M2_AWVALID, M1_ARVALID, M2_ARVALID, M1_WVALID, M1_WLAST} = '1;
      {S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID, S_RLAST, M1_BREADY, M1_RREADY} = '1;
      #2 rst_n = 1'b0;
      @(negedge aclk);
      checks++;
      if (all_vr !== '0) begin
         failures++;
         $display("FAIL reset_outs got %b want 0", all_vr);
      end
      clear_inputs();
      tick();
      rst_n = 1'b1;
      @(negedge aclk);
      checks++;
      if (all_vr !== '0) begin
         failures++;
         $display("FAIL idle_outs got %b want 0", all_vr);
      end
      tick();
   endtask

   task automatic test_single_write();
      m1_grant_w = 1'b1;
      aw_phase(1, 32'h100);
      w_burst(1, 4, 32'h1000, 1'b1);
      b_phase(1, 2'b00);
      m1_grant_w = 1'b0;
   endtask

   task automatic test_back_to_back();
      m1_grant_w = 1'b1;
      aw_phase(1, 32'h200);
      w_burst(1, 2, 32'h2000, 1'b0);
      m1_grant_w = 1'b0;
      m2_grant_w = 1'b1;
      M2_AWADDR  = 32'h300;
      M2_AWVALID = 1'b1;
      S_AWREADY  = 1'b1;
      w_burst(1, 2, 32'h2002, 1'b1);
      b_phase(1, 2'b00);
      aw_phase(2, 32'h300);
      w_burst(2, 1, 32'h3000, 1'b1);
      b_phase(2, 2'b01);
      m2_grant_w = 1'b0;
   endtask

   task automatic test_concurrent();
      m1_grant_w = 1'b1;
      m2_grant_r = 1'b1;
      aw_phase(1, 32'h400);
      ar_phase(2, 32'h500);
      r_burst(2, 4, 32'h5000, 1'b0);
      w_burst(1, 2, 32'h4000, 1'b1);
      b_phase(1, 2'b00);
      {m1_grant_w, m2_grant_r} = '0;
   endtask

   task automatic test_read_priority();
      m1_grant_r = 1'b1;
      m2_grant_r = 1'b1;
      M2_ARADDR  = 32'h700;
      M2_ARVALID = 1'b1;
      ar_phase(1, 32'h600);
      M2_ARVALID = 1'b0;
      r_burst(1, 8, 32'h6000, 1'b1);
      {m1_grant_r, m2_grant_r} = '0;
   endtask

   task automatic test_reset_in_resp();
      m1_grant_w = 1'b1;
      aw_phase(1, 32'h800);
      w_burst(1, 1, 32'h8000, 1'b1);
      S_BVALID   = 1'b1;
      M1_BREADY  = 1'b1;
      M1_AWVALID = 1'b1;
      @(negedge aclk);
      checks++;
      if (M1_BVALID !== 1'b1) begin
         failures++;
         $display("FAIL b_pre got %b want 1", M1_BVALID);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (all_vr !== '0) begin
         failures++;
         $display("FAIL rst_async got %b want 0", all_vr);
      end
      tick();
      rst_n = 1'b1;
      @(negedge aclk);
      checks++;
      if ({M1_BVALID, M2_BVALID, S_BREADY} !== 3'b000) begin
         failures++;
         $display("FAIL rst_no_b got %b want 000", {M1_BVALID, M2_BVALID, S_BREADY});
      end
      checks++;
      if ({S_AWVALID, S_AWADDR} !== {1'b1, 32'h800}) begin
         failures++;
         $display("FAIL rst_idle got %b/%h want 1/800", S_AWVALID, S_AWADDR);
      end
      tick();
      {M1_AWVALID, S_BVALID, M1_BREADY, m1_grant_w} = '0;
      tick();
   endtask

   task automatic test_early_bvalid();
      m1_grant_w = 1'b1;
      aw_phase(1, 32'h900);
      S_BVALID  = 1'b1;
      S_BRESP   = 2'b11;
      M1_BREADY = 1'b1;
      w_burst(1, 3, 32'h9000, 1'b1);
      b_phase(1, 2'b10);
      m1_grant_w = 1'b0;
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_write();
      test_back_to_back();
      test_concurrent();
      test_read_priority();
      test_reset_in_resp();
      test_early_bvalid();
      checks++;
      if (wq.size() != 0 || rq.size() != 0) begin
         failures++;
         $display("FAIL sb_drain wq=%0d rq=%0d want 0/0", wq.size(), rq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end
endmodule
